// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared lock state encoding and field widths
package lock_pkg;

    localparam int STATE_W = 3;
    localparam int DIGIT_W = 4;

    // Encoding is shared with the digit-entry stage, which compares against it.
    typedef enum logic [STATE_W-1:0] {
        S_OPEN    = 3'd0,
        S_LOCKED  = 3'd1,
        S_CHECK   = 3'd2,
        S_LOCKOUT = 3'd3
    } lock_state_t;

endpackage

// File: rtl/code_check_fsm_if.sv
// rtl/code_check_fsm_if.sv - lock controller signal bundle
// master: digit-entry side (drives button_confirm, digits)
// slave : lock controller (drives state, unlocked, alarm, busy, fail_count, entry_clear)
interface code_check_fsm_if #(
    parameter int DIGITS = 8
);
    import lock_pkg::*;

    logic                        button_confirm;
    logic [DIGIT_W*DIGITS-1:0]   digits;
    logic [STATE_W-1:0]          state;
    logic                        unlocked;
    logic                        alarm;
    logic                        busy;
    logic [3:0]                  fail_count;
    logic                        entry_clear;

    modport master (
        output button_confirm, digits,
        input  state, unlocked, alarm, busy, fail_count, entry_clear
    );

    modport slave (
        input  button_confirm, digits,
        output state, unlocked, alarm, busy, fail_count, entry_clear
    );

endinterface

// File: rtl/code_check_fsm_lockout_timer.sv
// rtl/code_check_fsm_lockout_timer.sv - one-shot lockout interval counter
// Ports: clk, rst (sync active-high), start (restart from 0), clear (stop),
//        done (high on the last cycle of the interval)
module lockout_timer #(
    parameter int LOCKOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clear,
    output logic done
);

    localparam int               CNT_W = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(LOCKOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic             running_q;

    // Count 0 is the first cycle after start, so the interval spans
    // exactly LOCKOUT_CYCLES cycles.
    assign done = running_q && (count_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            running_q <= 1'b0;
        end else if (start) begin
            count_q   <= '0;
            running_q <= 1'b1;
        end else if (clear || done) begin
            count_q   <= '0;
            running_q <= 1'b0;
        end else if (running_q) begin
            count_q   <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/code_check_fsm.sv
// rtl/code_check_fsm.sv - code store/compare lock controller with lockout
// Ports: clk, rst (sync active-high), bus (slave): button_confirm, digits in;
//        state, unlocked, alarm, busy, fail_count, entry_clear out
module code_check_fsm
    import lock_pkg::*;
#(
    parameter int DIGITS         = 8,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    code_check_fsm_if.slave   bus
);

    localparam int               CODE_W   = DIGITS * DIGIT_W;
    localparam int               IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [3:0]       MAX_F    = 4'(MAX_FAILS);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CODE_W-1:0]  code_q, snap_q;
    logic [IDX_W-1:0]   idx_q;
    logic               mismatch_q;
    logic [3:0]         fail_q;
    logic               entry_clear_q;
    logic               confirm_q;

    logic               confirm_evt;
    logic [DIGIT_W-1:0] snap_digit, code_digit;
    logic               check_last;
    logic               check_bad;
    logic [3:0]         fail_inc;
    logic               fail_limit;
    logic               timer_start;
    logic               timer_done;

    assign confirm_evt = bus.button_confirm & ~confirm_q;

    // One digit per cycle; the current digit's result is folded in so the
    // verdict is ready on the last compare cycle without an extra cycle.
    assign snap_digit  = snap_q[int'(idx_q)*DIGIT_W +: DIGIT_W];
    assign code_digit  = code_q[int'(idx_q)*DIGIT_W +: DIGIT_W];
    assign check_last  = (state_q == S_CHECK) && (idx_q == LAST_IDX);
    assign check_bad   = mismatch_q | (snap_digit != code_digit);
    assign fail_inc    = fail_q + 4'd1;
    assign fail_limit  = (fail_inc >= MAX_F);
    assign timer_start = check_last & check_bad & fail_limit;

    lockout_timer #(
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .start (timer_start),
        .clear (state_q != S_LOCKOUT),
        .done  (timer_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_OPEN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_OPEN:    if (confirm_evt) state_d = S_LOCKED;
            S_LOCKED:  if (confirm_evt) state_d = S_CHECK;
            S_CHECK: begin
                if (check_last) begin
                    if (!check_bad)      state_d = S_OPEN;
                    else if (fail_limit) state_d = S_LOCKOUT;
                    else                 state_d = S_LOCKED;
                end
            end
            S_LOCKOUT: if (timer_done) state_d = S_LOCKED;
            default:   state_d = S_LOCKED;
        endcase
    end

    always_comb begin
        bus.state       = state_q;
        bus.unlocked    = (state_q == S_OPEN);
        bus.alarm       = (state_q == S_LOCKOUT);
        bus.busy        = (state_q == S_CHECK);
        bus.fail_count  = fail_q;
        bus.entry_clear = entry_clear_q;
    end

    // Datapath registers; entry_clear is registered so it lines up with the
    // first cycle of the state it accompanies.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q        <= '0;
            snap_q        <= '0;
            idx_q         <= '0;
            mismatch_q    <= 1'b0;
            fail_q        <= 4'd0;
            entry_clear_q <= 1'b0;
            confirm_q     <= 1'b0;
        end else begin
            confirm_q     <= bus.button_confirm;
            entry_clear_q <= 1'b0;
            case (state_q)
                S_OPEN: begin
                    if (confirm_evt) begin
                        code_q        <= bus.digits;
                        entry_clear_q <= 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (confirm_evt) begin
                        snap_q     <= bus.digits;
                        idx_q      <= '0;
                        mismatch_q <= 1'b0;
                    end
                end
                S_CHECK: begin
                    mismatch_q <= check_bad;
                    idx_q      <= idx_q + 1'b1;
                    if (check_last) begin
                        idx_q         <= '0;
                        entry_clear_q <= 1'b1;
                        if (!check_bad)      fail_q <= 4'd0;
                        else if (fail_limit) fail_q <= MAX_F;
                        else                 fail_q <= fail_inc;
                    end
                end
                S_LOCKOUT: begin
                    if (timer_done) fail_q <= 4'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/code_check_fsm.md
Name: code_check_fsm

Overview:
Lock controller that sits directly downstream of the digit-entry stage. It consumes the 8 entered BCD digits and a confirm button, stores the secret code, and compares each entry attempt against it one digit per cycle. It tracks failed attempts, enforces a timed lockout, and drives the 3-bit lock state that the digit-entry stage gates its increments on.

Parameters:
DIGITS, 8, number of BCD digits in the code (1..8)
MAX_FAILS, 3, consecutive failed attempts that trigger lockout (1..15)
LOCKOUT_CYCLES, 50_000_000, clk cycles spent in lockout (>=1)

Ports:
clk  input  1  system clock; all logic rising-edge
rst  input  1  synchronous, active-high reset
button_confirm  input  1  confirm button, already synchronized/debounced level
digits  input  4*DIGITS  entered digits, digit1 in bits [3:0], digit2 in [7:4], ...
state  output  3  lock state encoding (see Behaviour); feeds digit-entry state comparison
unlocked  output  1  high while state==S_OPEN
alarm  output  1  high while state==S_LOCKOUT
busy  output  1  high while state==S_CHECK
fail_count  output  4  consecutive failed attempts
entry_clear  output  1  one-cycle pulse requesting digit-entry registers to clear

Behaviour:
- Reset: state=S_OPEN, stored code=0, snapshot=0, fail_count=0, idx=0, mismatch=0, lockout timer=0, entry_clear=0, confirm_q=0.
- Confirm event = button_confirm high now, confirm_q (last cycle) low; one event per press; holding produces nothing more.
- State encoding (shared package): S_OPEN=3'd0, S_LOCKED=3'd1, S_CHECK=3'd2, S_LOCKOUT=3'd3; 4..7 unused -> next cycle S_LOCKED.
- S_OPEN: confirm at cycle T -> code <= digits at T; state=S_LOCKED and entry_clear=1 at T+1; fail_count unchanged (already 0).
- S_LOCKED: confirm at T -> snapshot <= digits, idx<=0, mismatch<=0, state=S_CHECK at T+1. Later digit changes ignored.
- S_CHECK: each cycle compares snapshot digit[idx] vs code digit[idx]; any inequality sets sticky mismatch; idx increments. Compare cycles T+1..T+DIGITS. At T+DIGITS+1:
  - match: state=S_OPEN, fail_count=0, entry_clear pulse.
  - mismatch and fail_count+1 < MAX_FAILS: fail_count+1, state=S_LOCKED, entry_clear pulse.
  - mismatch and fail_count+1 == MAX_FAILS: fail_count=MAX_FAILS, timer=0, state=S_LOCKOUT, entry_clear pulse.
  - Confirm events during S_CHECK are ignored (not queued).
- S_LOCKOUT: timer counts up each cycle; at timer==LOCKOUT_CYCLES-1 next state S_LOCKED, fail_count=0. Confirm ignored.
- entry_clear: exactly one cycle, asserted together with the first cycle of the new state; otherwise 0.
- Digits treated as 4-bit raw values; values 10..15 compared bitwise, no saturation.
- fail_count never exceeds MAX_FAILS; timer width = $clog2(LOCKOUT_CYCLES+1).
- rst mid-CHECK or mid-LOCKOUT: immediate return to reset values next edge; stored code is lost (lock opens).
- unlocked/alarm/busy are decoded from the state register (no extra latency).

Decomposition:
- Package lock_pkg: state enum/localparams S_OPEN..S_LOCKOUT, STATE_W=3, DIGIT_W=4.
- One sub-module natural: lockout_timer (start, clear, done pulse, parameter LOCKOUT_CYCLES). Edge detect and compare stay inline.

Test Plan:
- Reset then digits=0x12345678, confirm -> state 0->1 next cycle, entry_clear one pulse, unlocked=0.
- Code 0x12345678 stored; enter 0x12345678, confirm at T -> busy T+1..T+8, state=0 and fail_count=0 at T+9.
- Enter 0x12345679 (last digit differs) -> state=1 at T+9, fail_count=1; change digits during CHECK -> no effect on result.
- Three consecutive wrong attempts, MAX_FAILS=3, LOCKOUT_CYCLES=20 -> state=3, alarm=1 for 20 cycles, confirm presses ignored, then state=1 and fail_count=0.
- Hold button_confirm high 30 cycles in S_LOCKED -> exactly one CHECK; confirm pulse during CHECK -> ignored.
- Assert rst during CHECK cycle 4 -> next edge state=0, fail_count=0, entry_clear=0, busy=0.
